// File: rtl/cmd_phys_param.sv
// cmd_phys_param: SD command-line physical layer with response capture.
//
// Serialises a host command frame (payload MSB first, CRC7, end bit) onto
// the CMD pad, then optionally captures a RESP_SHORT- or RESP_LONG-bit card
// response with a start-bit timeout.
//
// Optional feature macro: CMD_PHYS_CRC7_EN
//   defined   : CRC7 generated on transmit, checked on short responses
//   undefined : CRC field sent as all ones, crc_error tied low, no CRC logic
//
// Ports:
//   sd_clock     block clock
//   reset        asynchronous reset, active-low
//   strobe_in    command request (accepted only in IDLE)
//   ack_in       controller has consumed the response
//   idle_in      abort to IDLE (priority over strobe_in)
//   cmd_to_send  command payload, MSB first
//   long_resp_in expect a RESP_LONG response (sampled with strobe_in)
//   no_resp_in   expect no response (sampled with strobe_in, wins over long)
//   cmd_pin_in   CMD pad input
//   cmd_pin_out  CMD pad output data (1 when not driving)
//   cmd_oe       CMD pad output enable (high only while sending)
//   ack_out      one-cycle command-accepted pulse
//   strobe_out   response/completion valid, held until ack_in
//   response     captured response, right-aligned
//   timeout      no start bit arrived, valid with strobe_out
//   crc_error    short-response CRC mismatch, valid with strobe_out
//   busy         high in every state except IDLE
module cmd_phys_param #(
  parameter int CMD_WIDTH  = 40,
  parameter int RESP_SHORT = 48,
  parameter int RESP_LONG  = 136,
  parameter int TIMEOUT    = 64
) (
  input  logic                 sd_clock,
  input  logic                 reset,
  input  logic                 strobe_in,
  input  logic                 ack_in,
  input  logic                 idle_in,
  input  logic [CMD_WIDTH-1:0] cmd_to_send,
  input  logic                 long_resp_in,
  input  logic                 no_resp_in,
  input  logic                 cmd_pin_in,
  output logic                 cmd_pin_out,
  output logic                 cmd_oe,
  output logic                 ack_out,
  output logic                 strobe_out,
  output logic [RESP_LONG-1:0] response,
  output logic                 timeout,
  output logic                 crc_error,
  output logic                 busy
);

  localparam int TX_BITS = CMD_WIDTH + 8;
  localparam int TXW     = $clog2(TX_BITS + 1);
  localparam int RXW     = $clog2(RESP_LONG + 1);
  localparam int WTW     = $clog2(TIMEOUT + 1);

  localparam logic [TXW-1:0] TX_LAST       = TXW'(TX_BITS - 1);
  localparam logic [TXW-1:0] TX_PAY_END    = TXW'(CMD_WIDTH);
  localparam logic [RXW-1:0] RX_SHORT_LAST = RXW'(RESP_SHORT - 1);
  localparam logic [RXW-1:0] RX_LONG_LAST  = RXW'(RESP_LONG - 1);
  localparam logic [WTW-1:0] WAIT_LAST     = WTW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RESP,
    S_RECEIVE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CMD_WIDTH-1:0] r_tx;
  logic [TXW-1:0]       r_tx_cnt;
  logic [RXW-1:0]       r_rx_cnt;
  logic [WTW-1:0]       r_wait_cnt;
  logic [RESP_LONG-1:0] r_resp;
  logic                 r_long;
  logic                 r_no_resp;
  logic                 r_ack;
  logic                 r_timeout;
  logic                 w_tx_bit;
  logic                 w_rx_last;

`ifdef CMD_PHYS_CRC7_EN
  localparam logic [RXW-1:0] RX_CRC_END = RXW'(RESP_SHORT - 8);

  logic [6:0] r_tx_crc;
  logic [6:0] r_rx_crc;
  logic       r_crc_err;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] f_crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction
`endif

  assign w_rx_last = (r_rx_cnt == (r_long ? RX_LONG_LAST : RX_SHORT_LAST));

  // Bit on the pad during SEND: payload, then CRC field, then end bit.
`ifdef CMD_PHYS_CRC7_EN
  assign w_tx_bit = (r_tx_cnt < TX_PAY_END) ? r_tx[CMD_WIDTH-1] :
                    (r_tx_cnt == TX_LAST)   ? 1'b1 : r_tx_crc[6];
`else
  assign w_tx_bit = (r_tx_cnt < TX_PAY_END) ? r_tx[CMD_WIDTH-1] : 1'b1;
`endif

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (idle_in) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (strobe_in) w_next = S_SEND;
        S_SEND:      if (r_tx_cnt == TX_LAST) w_next = r_no_resp ? S_DONE : S_WAIT_RESP;
        S_WAIT_RESP: begin
          if (!cmd_pin_in)                  w_next = S_RECEIVE;
          else if (r_wait_cnt == WAIT_LAST) w_next = S_DONE;
        end
        S_RECEIVE:   if (w_rx_last) w_next = S_DONE;
        S_DONE:      if (ack_in) w_next = S_IDLE;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      r_tx       <= '0;
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_wait_cnt <= '0;
      r_resp     <= '0;
      r_long     <= 1'b0;
      r_no_resp  <= 1'b0;
      r_ack      <= 1'b0;
      r_timeout  <= 1'b0;
`ifdef CMD_PHYS_CRC7_EN
      r_tx_crc   <= '0;
      r_rx_crc   <= '0;
      r_crc_err  <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
      if (idle_in) begin
        r_tx_cnt   <= '0;
        r_rx_cnt   <= '0;
        r_wait_cnt <= '0;
        r_timeout  <= 1'b0;
`ifdef CMD_PHYS_CRC7_EN
        r_crc_err  <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (strobe_in) begin
              r_tx      <= cmd_to_send;
              r_long    <= long_resp_in & ~no_resp_in;
              r_no_resp <= no_resp_in;
              r_ack     <= 1'b1;
              r_tx_cnt  <= '0;
              r_timeout <= 1'b0;
`ifdef CMD_PHYS_CRC7_EN
              r_tx_crc  <= '0;
              r_rx_crc  <= '0;
              r_crc_err <= 1'b0;
`endif
            end
          end
          S_SEND: begin
            // Previous response stays visible until the new frame is on the wire.
            if (r_tx_cnt == TX_LAST) begin
              r_tx_cnt   <= '0;
              r_wait_cnt <= '0;
              r_resp     <= '0;
            end else begin
              r_tx_cnt <= r_tx_cnt + TXW'(1);
            end
            if (r_tx_cnt < TX_PAY_END) begin
              r_tx <= {r_tx[CMD_WIDTH-2:0], 1'b0};
`ifdef CMD_PHYS_CRC7_EN
              r_tx_crc <= f_crc7_step(r_tx_crc, r_tx[CMD_WIDTH-1]);
            end else begin
              r_tx_crc <= {r_tx_crc[5:0], 1'b0};
`endif
            end
          end
          S_WAIT_RESP: begin
            if (!cmd_pin_in) begin
              // Start bit is response bit 0 of the frame; CRC of a lone 0 from 0 stays 0.
              r_resp   <= {r_resp[RESP_LONG-2:0], cmd_pin_in};
              r_rx_cnt <= RXW'(1);
            end else if (r_wait_cnt == WAIT_LAST) begin
              r_timeout  <= 1'b1;
              r_wait_cnt <= '0;
            end else begin
              r_wait_cnt <= r_wait_cnt + WTW'(1);
            end
          end
          S_RECEIVE: begin
            r_resp <= {r_resp[RESP_LONG-2:0], cmd_pin_in};
            if (w_rx_last) begin
              r_rx_cnt <= '0;
`ifdef CMD_PHYS_CRC7_EN
              // Before this final shift, r_resp[6:0] holds frame bits [7:1].
              r_crc_err <= ~r_long & (r_resp[6:0] != r_rx_crc);
`endif
            end else begin
              r_rx_cnt <= r_rx_cnt + RXW'(1);
            end
`ifdef CMD_PHYS_CRC7_EN
            if (r_rx_cnt < RX_CRC_END) r_rx_crc <= f_crc7_step(r_rx_crc, cmd_pin_in);
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Pad controls decode straight from state so reset releases the pad asynchronously.
  assign cmd_oe      = (r_state == S_SEND);
  assign cmd_pin_out = (r_state == S_SEND) ? w_tx_bit : 1'b1;
  assign ack_out     = r_ack;
  assign strobe_out  = (r_state == S_DONE);
  assign timeout     = (r_state == S_DONE) & r_timeout;
  assign busy        = (r_state != S_IDLE);
  assign response    = r_resp;
`ifdef CMD_PHYS_CRC7_EN
  assign crc_error   = (r_state == S_DONE) & r_crc_err;
`else
  assign crc_error   = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_phys_param.sv
module tb_cmd_phys_param;

  localparam int CW  = 40;
  localparam int RS  = 48;
  localparam int RL  = 136;
  localparam int TO  = 64;
  localparam int TXB = CW + 8;

`ifdef CMD_PHYS_CRC7_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  // Frame tails {CRC7, end bit}, hand-computed: CMD0 -> 0x95, CMD8(1AA) -> 0x87, CMD17(0) -> 0x55.
  localparam logic [7:0] TAIL0  = CRC_ON ? 8'h95 : 8'hFF;
  localparam logic [7:0] TAIL8  = CRC_ON ? 8'h87 : 8'hFF;
  localparam logic [7:0] TAIL17 = CRC_ON ? 8'h55 : 8'hFF;

  localparam logic [CW-1:0] CMD0  = 40'h40_0000_0000;
  localparam logic [CW-1:0] CMD8  = 40'h48_0000_01AA;
  localparam logic [CW-1:0] CMD17 = 40'h51_0000_0000;

  logic          sd_clock = 1'b0;
  logic          reset = 1'b0;
  logic          strobe_in = 1'b0;
  logic          ack_in = 1'b0;
  logic          idle_in = 1'b0;
  logic [CW-1:0] cmd_to_send = '0;
  logic          long_resp_in = 1'b0;
  logic          no_resp_in = 1'b0;
  logic          cmd_pin_in = 1'b1;
  logic          cmd_pin_out;
  logic          cmd_oe;
  logic          ack_out;
  logic          strobe_out;
  logic [RL-1:0] response;
  logic          timeout;
  logic          crc_error;
  logic          busy;

  cmd_phys_param #(
    .CMD_WIDTH (CW),
    .RESP_SHORT(RS),
    .RESP_LONG (RL),
    .TIMEOUT   (TO)
  ) dut (
    .sd_clock    (sd_clock),
    .reset       (reset),
    .strobe_in   (strobe_in),
    .ack_in      (ack_in),
    .idle_in     (idle_in),
    .cmd_to_send (cmd_to_send),
    .long_resp_in(long_resp_in),
    .no_resp_in  (no_resp_in),
    .cmd_pin_in  (cmd_pin_in),
    .cmd_pin_out (cmd_pin_out),
    .cmd_oe      (cmd_oe),
    .ack_out     (ack_out),
    .strobe_out  (strobe_out),
    .response    (response),
    .timeout     (timeout),
    .crc_error   (crc_error),
    .busy        (busy)
  );

  always #5 sd_clock = ~sd_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [RL-1:0] resp;
    logic          to;
    logic          ce;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic mon_prev = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chkw(input string name, input logic [RL-1:0] act, input logic [RL-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic expect_resp(input logic [RL-1:0] resp, input logic to, input logic ce);
    exp_t e;
    e.resp = resp;
    e.to   = to;
    e.ce   = ce;
    sb.push_back(e);
  endtask

  // Monitor: every rising strobe_out consumes one expected completion.
  always @(negedge sd_clock) begin
    if (strobe_out && !mon_prev) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_strobe: strobe_out=1 with no outstanding command");
      end else begin
        mon_e = sb.pop_front();
        chkw("response", response, mon_e.resp);
        chk1("timeout", timeout, mon_e.to);
        chk1("crc_error", crc_error, mon_e.ce);
      end
    end
    mon_prev = strobe_out;
  end

  // Issue a command at a negedge and capture the serial frame; ends at the end-bit cycle.
  task automatic issue(input logic [CW-1:0] cmd, input logic lng, input logic nr, input logic [7:0] tail);
    logic [TXB-1:0] frame;
    logic           oe_ok;
    cmd_to_send  = cmd;
    long_resp_in = lng;
    no_resp_in   = nr;
    strobe_in    = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    chk1("ack_pulse", ack_out, 1'b1);
    frame = '0;
    oe_ok = 1'b1;
    for (int k = 0; k < TXB; k++) begin
      if (k > 0) @(negedge sd_clock);
      if (k == 1) chk1("ack_one_cycle", ack_out, 1'b0);
      frame[TXB-1-k] = cmd_pin_out;
      oe_ok = oe_ok & cmd_oe;
    end
    chkw("tx_frame", RL'(frame), RL'({cmd, tail}));
    chk1("oe_whole_frame", oe_ok, 1'b1);
  endtask

  // Card drives a response whose start bit is sampled `delay` cycles after the end bit.
  task automatic card_send(input logic [RL-1:0] bits, input int nbits, input int delay, input bit poke);
    for (int d = 1; d <= delay; d++) begin
      @(negedge sd_clock);
      if (d == 1) chk1("oe_released", cmd_oe, 1'b0);
      if (poke && d == 2) strobe_in = 1'b1;
      if (poke && d == 3) begin
        strobe_in = 1'b0;
        chk1("ignored_strobe_no_ack", ack_out, 1'b0);
      end
    end
    for (int i = nbits - 1; i >= 0; i--) begin
      cmd_pin_in = bits[i];
      @(negedge sd_clock);
    end
    cmd_pin_in = 1'b1;
  endtask

  task automatic finish_ack(input bit with_strobe);
    int n;
    n = 0;
    while (!strobe_out && n < 400) begin
      @(negedge sd_clock);
      n++;
    end
    chk1("strobe_arrived", strobe_out, 1'b1);
    ack_in    = 1'b1;
    strobe_in = with_strobe;
    @(negedge sd_clock);
    ack_in    = 1'b0;
    strobe_in = 1'b0;
    chk1("strobe_cleared_by_ack", strobe_out, 1'b0);
    chk1("idle_after_ack", busy, 1'b0);
    if (with_strobe) begin
      chk1("no_accept_in_done", ack_out, 1'b0);
      @(negedge sd_clock);
      chk1("still_idle", busy, 1'b0);
    end
  endtask

  logic [RL-1:0] long_pat;
  logic          saw;
  int            n;

  initial begin
    long_pat = {34{4'h5}};

    // Reset values
    repeat (2) @(negedge sd_clock);
    chk1("rst_pin_out", cmd_pin_out, 1'b1);
    chk1("rst_oe", cmd_oe, 1'b0);
    chk1("rst_ack", ack_out, 1'b0);
    chk1("rst_strobe", strobe_out, 1'b0);
    chkw("rst_response", response, '0);
    chk1("rst_timeout", timeout, 1'b0);
    chk1("rst_crc_error", crc_error, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(negedge sd_clock);

    // CMD0, no response: completion right after the end bit
    expect_resp('0, 1'b0, 1'b0);
    issue(CMD0, 1'b0, 1'b1, TAIL0);
    @(negedge sd_clock);
    chk1("oe_released_nr", cmd_oe, 1'b0);
    chk1("done_after_end_bit", strobe_out, 1'b1);
    finish_ack(1'b0);

    // CMD8 with a valid short response
    expect_resp(RL'(48'h48_0000_01AA_87), 1'b0, 1'b0);
    issue(CMD8, 1'b0, 1'b0, TAIL8);
    card_send(RL'(48'h48_0000_01AA_87), RS, 5, 1'b0);
    finish_ack(1'b0);

    // One argument bit flipped, plus an ignored strobe during WAIT_RESP and strobe+ack in DONE
    expect_resp(RL'(48'h48_0000_01AB_87), 1'b0, CRC_ON);
    issue(CMD8, 1'b0, 1'b0, TAIL8);
    card_send(RL'(48'h48_0000_01AB_87), RS, 5, 1'b1);
    finish_ack(1'b1);

    // Timeout: pad held high
    expect_resp('0, 1'b1, 1'b0);
    issue(CMD17, 1'b0, 1'b0, TAIL17);
    n = 0;
    while (!strobe_out && n < 100) begin
      @(negedge sd_clock);
      n++;
    end
    chki("timeout_latency", n, TO + 1);
    chk1("busy_in_done", busy, 1'b1);
    finish_ack(1'b0);

    // long_resp_in and no_resp_in together: no response expected
    expect_resp('0, 1'b0, 1'b0);
    issue(CMD0, 1'b1, 1'b1, TAIL0);
    @(negedge sd_clock);
    chk1("no_resp_wins", strobe_out, 1'b1);
    finish_ack(1'b0);

    // Long response
    expect_resp(long_pat, 1'b0, 1'b0);
    issue(CMD8, 1'b1, 1'b0, TAIL8);
    card_send(long_pat, RL, 5, 1'b0);
    finish_ack(1'b0);

    // Abort with idle_in at payload bit 10
    cmd_to_send  = CMD8;
    long_resp_in = 1'b0;
    no_resp_in   = 1'b0;
    strobe_in    = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    repeat (10) @(negedge sd_clock);
    chk1("oe_before_abort", cmd_oe, 1'b1);
    idle_in = 1'b1;
    @(negedge sd_clock);
    idle_in = 1'b0;
    chk1("abort_oe_low", cmd_oe, 1'b0);
    chk1("abort_idle", busy, 1'b0);
    saw = 1'b0;
    repeat (TO + TXB + 20) begin
      @(negedge sd_clock);
      saw = saw | strobe_out;
    end
    chk1("no_strobe_after_abort", saw, 1'b0);

    // Asynchronous reset mid-SEND
    cmd_to_send = CMD0;
    no_resp_in  = 1'b1;
    strobe_in   = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    repeat (4) @(negedge sd_clock);
    chk1("mid_send_oe", cmd_oe, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("async_rst_oe", cmd_oe, 1'b0);
    chk1("async_rst_pin", cmd_pin_out, 1'b1);
    chk1("async_rst_busy", busy, 1'b0);
    chkw("async_rst_response", response, '0);
    @(negedge sd_clock);
    reset = 1'b1;
    repeat (2) @(negedge sd_clock);

    chki("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
